config_bus_master: RTL and testbench

- Initiator end of the NI configuration bus.
- Accepts one read/write request at a time from the upstream config source (packet decoder or local processor bridge) over a valid/ready handshake.
- Decodes the target bank from the upper address bits and drives config_addr/en/wr/wdata plus a one-hot bank select.
- Captures the selected slave's registered rdata/error one cycle after the access and returns it on a valid/ready response channel. Slaves include the TDM controller, schedule table and DMA table.

---
 rtl/config_pkg.sv | 17 +
 rtl/config_rsp_mux.sv | 33 +++
 rtl/config_bus_master.sv | 133 +++++++++++++
 tb/tb_config_bus_master.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the NI configuration bus master.
// This package holds the bus widths, the bank field position and the FSM state type.
package config_pkg;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int BANK_LSB = 11;
  localparam int BANK_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/config_rsp_mux.sv
// Combinational response selection.
// Picks the addressed slave's rdata/error, returning zero data for writes and a forced error for illegal banks.
module config_rsp_mux
  import config_pkg::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic [NUM_BANKS*DATA_W-1:0] i_slv_rdata,
  input  logic [NUM_BANKS-1:0]        i_slv_error,
  input  logic [BANK_W-1:0]           i_bank,
  input  logic                        i_legal,
  input  logic                        i_wr,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_error
);

  // The loop compares against each real bank, so an illegal index never indexes past the bus.
  always_comb begin
    o_rdata = '0;
    o_error = 1'b1;
    if (i_legal) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (int'(i_bank) == b) begin
          o_error = i_slv_error[b];
          if (!i_wr) begin
            o_rdata = i_slv_rdata[b*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/config_bus_master.sv
// Initiator end of the NI configuration bus.
// It accepts one request at a time, issues a one-cycle bank strobe and returns the slave reply.
module config_bus_master
  import config_pkg::*;
#(
  parameter int NUM_BANKS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wr,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_error,
  output logic [ADDR_W-1:0]           config_addr,
  output logic                        config_en,
  output logic                        config_wr,
  output logic [DATA_W-1:0]           config_wdata,
  output logic [NUM_BANKS-1:0]        config_sel,
  input  logic [NUM_BANKS*DATA_W-1:0] slv_rdata,
  input  logic [NUM_BANKS-1:0]        slv_error
);

  state_t                r_state;
  logic                  r_wr;
  logic                  r_legal;
  logic [BANK_W-1:0]     r_bank;
  logic                  r_rsp_valid;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_error;
  logic                  r_cfg_en;
  logic                  r_cfg_wr;
  logic [ADDR_W-1:0]     r_cfg_addr;
  logic [DATA_W-1:0]     r_cfg_wdata;
  logic [NUM_BANKS-1:0]  r_cfg_sel;

  logic [BANK_W-1:0]     w_req_bank;
  logic                  w_req_legal;
  logic [NUM_BANKS-1:0]  w_req_sel;
  logic [DATA_W-1:0]     w_mux_rdata;
  logic                  w_mux_error;

  assign w_req_bank  = req_addr[BANK_LSB +: BANK_W];
  assign w_req_legal = (int'(w_req_bank) < NUM_BANKS);
  assign w_req_sel   = w_req_legal ? (NUM_BANKS'(1) << w_req_bank) : '0;

  config_rsp_mux #(
    .NUM_BANKS (NUM_BANKS)
  ) u_rsp_mux (
    .i_slv_rdata (slv_rdata),
    .i_slv_error (slv_error),
    .i_bank      (r_bank),
    .i_legal     (r_legal),
    .i_wr        (r_wr),
    .o_rdata     (w_mux_rdata),
    .o_error     (w_mux_error)
  );

  // Bus outputs are loaded on the accept edge so they appear in the ACCESS cycle.
  // They are cleared on the following edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr        <= 1'b0;
      r_legal     <= 1'b0;
      r_bank      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_cfg_wr    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_cfg_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wr    <= req_wr;
            r_legal <= w_req_legal;
            r_bank  <= w_req_bank;
            r_state <= ACCESS;
            if (w_req_legal) begin
              r_cfg_en    <= 1'b1;
              r_cfg_wr    <= req_wr;
              r_cfg_addr  <= req_addr;
              r_cfg_wdata <= req_wdata;
              r_cfg_sel   <= w_req_sel;
            end
          end
        end
        ACCESS: begin
          r_cfg_en    <= 1'b0;
          r_cfg_wr    <= 1'b0;
          r_cfg_addr  <= '0;
          r_cfg_wdata <= '0;
          r_cfg_sel   <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          r_rsp_rdata <= w_mux_rdata;
          r_rsp_error <= w_mux_error;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_error    = r_rsp_error;
  assign config_en    = r_cfg_en;
  assign config_wr    = r_cfg_wr;
  assign config_addr  = r_cfg_addr;
  assign config_wdata = r_cfg_wdata;
  assign config_sel   = r_cfg_sel;

endmodule

// File: tb/tb_config_bus_master.sv
// Scoreboard bench for config_bus_master.
// Registered slave models, expected bus strobes and responses are queued when each request is accepted.
module tb_config_bus_master;

  localparam int NB = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] sel;
  } busExp_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acceptCycle;
  } rspExp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_error;
  logic [AW-1:0]    config_addr;
  logic             config_en;
  logic             config_wr;
  logic [DW-1:0]    config_wdata;
  logic [NB-1:0]    config_sel;
  logic [NB*DW-1:0] slv_rdata;
  logic [NB-1:0]    slv_error;

  logic [DW-1:0]    slvWord [NB];
  logic [NB-1:0]    slvErr;

  busExp_t busQ [$];
  rspExp_t rspQ [$];

  int vectorCount = 0;
  int missCount = 0;
  int cycleCount = 0;
  int lastAcceptCycle = 0;
  int lastHsCycle = 0;
  bit monitorOn = 0;
  logic prevEn = 1'b0;
  logic prevRspValid = 1'b0;
  logic [DW-1:0] prevRdata = '0;
  logic prevErr = 1'b0;

  config_bus_master #(
    .NUM_BANKS (NB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .config_addr  (config_addr),
    .config_en    (config_en),
    .config_wr    (config_wr),
    .config_wdata (config_wdata),
    .config_sel   (config_sel),
    .slv_rdata    (slv_rdata),
    .slv_error    (slv_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Slaves register their reply for one cycle only, then show inverted-error junk.
  // Sampling in the wrong cycle therefore shows up as a miscompare.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (config_en && config_sel[b]) begin
        slv_rdata[b*DW +: DW] <= slvWord[b];
        slv_error[b]          <= slvErr[b];
      end else begin
        slv_rdata[b*DW +: DW] <= 32'hBADBAD00 | DW'(b);
        slv_error[b]          <= ~slvErr[b];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, observed, expected, cycleCount);
    end
  endtask

  // The monitor compares strobes and responses against the queues.
  // It also checks strobe width, idle bus values, latency and response stability.
  always @(negedge clk) begin
    busExp_t be;
    rspExp_t re;
    if (monitorOn) begin
      if (config_en) begin
        checkOutput("enWidth", 64'(prevEn), 64'(0));
        if (busQ.size() == 0) begin
          checkOutput("busUnexpected", 64'(1), 64'(0));
        end else begin
          be = busQ.pop_front();
          checkOutput("busAddr", 64'(config_addr), 64'(be.addr));
          checkOutput("busWr", 64'(config_wr), 64'(be.wr));
          checkOutput("busWdata", 64'(config_wdata), 64'(be.wdata));
          checkOutput("busSel", 64'(config_sel), 64'(be.sel));
        end
      end
      if (req_ready || rsp_valid) begin
        checkOutput("busIdle", 64'({config_en, config_wr, config_sel, config_addr, config_wdata}), 64'(0));
      end
      if (rsp_valid && !prevRspValid) begin
        if (rspQ.size() == 0) checkOutput("rspUnexpected", 64'(1), 64'(0));
        else checkOutput("rspLatency", 64'(cycleCount - rspQ[0].acceptCycle), 64'(3));
      end
      if (rsp_valid && prevRspValid) begin
        checkOutput("rspStable", 64'({rsp_error, rsp_rdata}), 64'({prevErr, prevRdata}));
      end
      if (rsp_valid && rsp_ready && rspQ.size() > 0) begin
        re = rspQ.pop_front();
        checkOutput("rspRdata", 64'(rsp_rdata), 64'(re.rdata));
        checkOutput("rspError", 64'(rsp_error), 64'(re.err));
        lastHsCycle = cycleCount;
      end
    end
    prevEn       = config_en;
    prevRspValid = rsp_valid;
    prevRdata    = rsp_rdata;
    prevErr      = rsp_error;
  end

  // Drives one request, holds it until accepted, and queues what the bus and response must show.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input bit expectRsp);
    busExp_t be;
    rspExp_t re;
    logic [2:0] bank;
    bit legal;
    bit accepted;
    accepted = 0;
    bank  = addr[13:11];
    legal = (int'(bank) < NB);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 60 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready) begin
        accepted = 1;
        lastAcceptCycle = cycleCount;
        if (legal) begin
          be.addr  = addr;
          be.wr    = wr;
          be.wdata = wdata;
          be.sel   = NB'(1) << bank;
          busQ.push_back(be);
        end
        if (expectRsp) begin
          re.rdata       = (legal && !wr) ? slvWord[bank[1:0]] : '0;
          re.err         = legal ? slvErr[bank[1:0]] : 1'b1;
          re.acceptCycle = cycleCount;
          rspQ.push_back(re);
        end
      end
    end
    if (!accepted) checkOutput("acceptTimeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic waitIdle();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (rspQ.size() == 0 && req_ready) done = 1;
    end
    if (!done) checkOutput("idleTimeout", 64'(0), 64'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] rAddr;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_wr    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    slvErr    = '0;
    for (int b = 0; b < NB; b++) slvWord[b] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetReqReady", 64'(req_ready), 64'(1));
    checkOutput("resetRsp", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'(0));
    checkOutput("resetBus", 64'({config_en, config_wr, config_sel, config_addr, config_wdata}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    monitorOn = 1;

    $display("[TB] read bank 0");
    slvWord[0] = 32'h00000001;
    applyStimulus(1'b0, 14'h0004, 32'h0, 1);
    waitIdle();

    $display("[TB] write bank 1");
    slvWord[1] = 32'h55AA55AA;
    applyStimulus(1'b1, 14'h0805, 32'hDEADBEEF, 1);
    waitIdle();

    $display("[TB] illegal banks 6 and 4");
    applyStimulus(1'b0, 14'h3000, 32'h0, 1);
    waitIdle();
    applyStimulus(1'b0, 14'h2000, 32'h0, 1);
    waitIdle();

    $display("[TB] slave error on bank 2 read and write");
    slvWord[2] = 32'h12345678;
    slvErr[2]  = 1'b1;
    applyStimulus(1'b0, 14'h1000, 32'h0, 1);
    waitIdle();
    applyStimulus(1'b1, 14'h1004, 32'hA5A5A5A5, 1);
    waitIdle();
    slvErr[2] = 1'b0;

    $display("[TB] top legal bank 3");
    slvWord[3] = 32'hCAFEF00D;
    applyStimulus(1'b0, 14'h1803, 32'h0, 1);
    waitIdle();

    $display("[TB] back-pressure with pending request");
    slvWord[1] = 32'h0F1E2D3C;
    slvWord[3] = 32'h99887766;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 14'h0810, 32'h0, 1);
    fork
      applyStimulus(1'b1, 14'h1BFF, 32'h0BADF00D, 1);
      begin
        repeat (12) begin
          @(negedge clk);
          checkOutput("reqReadyBP", 64'(req_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    checkOutput("acceptAfterHs", 64'(lastAcceptCycle - lastHsCycle), 64'(1));
    waitIdle();

    $display("[TB] random transactions");
    for (int n = 0; n < 10; n++) begin
      for (int b = 0; b < NB; b++) slvWord[b] = $urandom;
      slvErr = NB'($urandom_range(0, 15));
      rAddr = AW'($urandom_range(0, 16383));
      applyStimulus(1'($urandom_range(0, 1)), rAddr, $urandom, 1);
      waitIdle();
    end
    slvErr = '0;

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b0, 14'h0808, 32'h0, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midResetEn", 64'(config_en), 64'(0));
    checkOutput("midResetRspValid", 64'(rsp_valid), 64'(0));
    checkOutput("midResetReqReady", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] recovery read after reset");
    slvWord[0] = 32'h0000BEEF;
    applyStimulus(1'b0, 14'h0020, 32'h0, 1);
    waitIdle();

    repeat (3) @(posedge clk);
    checkOutput("busQLeft", 64'(busQ.size()), 64'(0));
    checkOutput("rspQLeft", 64'(rspQ.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
